gyro_sample_port: RTL
=====================

// Module: gyro_sample_port
// PURPOSE
//  Downstream of the gyro tilt stage. Decimates the 16-bit X/Y/Z tilt stream by
//  block-averaging 2**AVG_LOG2 samples, then latches a coherent XYZ snapshot.
//  Exposes the snapshot to the MCU as a 4-word read-only MMIO register file,
//  with a data-ready interrupt and overrun tracking.
// PARAMETERS
//  AVG_LOG2   2   log2 of samples per averaged output (0 = passthrough, max 8)
// PORTS
//  CLK           in   1   system clock; all state on rising edge
//  RST           in   1   asynchronous, active-high reset
//  ENABLE        in   1   1 = accumulate/commit; 0 = clear accumulators and count
//  SAMPLE_VALID  in   1   1-cycle strobe: X/Y/Z hold a new sample this cycle
//  X, Y, Z       in   16  signed tilt values from the tilt stage
//  RD            in   1   MMIO read strobe, 1 cycle
//  ADDR          in   2   0=STATUS 1=X 2=Y 3=Z
//  RDATA         out  32  registered read data
//  INTR          out  1   level interrupt, equals READY
// BEHAVIOUR
//  Reset: RDATA=0, INTR=0, READY=0, OVR=0, OVF_CNT=0, snapshot X/Y/Z=0,
//   accumulators=0, sample count=0, FSM=ACC.
//  FSM: ACC -> COMMIT on a SAMPLE_VALID that is the 2**AVG_LOG2-th sample.
//   COMMIT -> ACC unconditionally after 1 cycle.
//  ACC state:
//   - Each SAMPLE_VALID adds the sign-extended sample to its accumulator
//     (16+AVG_LOG2 bits, signed) and increments the count.
//   - On the final sample: avg = (acc + sample) >>> AVG_LOG2 (arithmetic shift,
//     floor toward -inf). The average is registered; the count and
//     accumulators are cleared.
//  COMMIT state: the snapshot regs load the averages and READY is set to 1.
//   - Latency: final SAMPLE_VALID at cycle n -> snapshot/READY/INTR visible at n+1.
//   - AVG_LOG2=0: every SAMPLE_VALID commits at n+1.
//  SAMPLE_VALID during COMMIT cannot occur, because the upstream rate is much
//   less than 1/2 the clock rate. If it does occur, it is accumulated normally.
//  Overrun: a commit while READY==1 sets OVR (sticky) and increments OVF_CNT.
//   - OVF_CNT is 8 bits and saturates at 255.
//   - The snapshot is overwritten; the newest data wins.
//  Register map (read-only):
//   - STATUS = {16'b0, OVF_CNT[7:0], 6'b0, OVR, READY}
//   - X/Y/Z  = snapshot value sign-extended to 32 bits.
//  Reads:
//   - RD with ADDR at cycle n -> RDATA at n+1, held until the next RD.
//   - A read of Z (ADDR=3) clears READY, and therefore INTR, at n+1.
//   - A read of STATUS clears OVR and OVF_CNT at n+1.
//   - Reads of X/Y have no side effects.
//  Simultaneous events:
//   - Commit and Z read in the same cycle: RDATA returns the pre-commit Z.
//     READY ends at 1. No overrun is flagged, because that read consumed the
//     old data.
//   - Overrun and STATUS read in the same cycle: RDATA shows the pre-event
//     status. OVR ends at 1 and OVF_CNT ends at 1.
//  ENABLE=0: accumulators and count are cleared and no commits occur.
//   Snapshot, READY, OVR and reads are unaffected. Accumulation restarts from a
//   zero count on the first SAMPLE_VALID after ENABLE returns to 1.
//  RST mid-accumulation or mid-COMMIT discards the partial average and all
//   state returns to reset values immediately (asynchronous).
// TESTING
//  1. AVG_LOG2=2, feed X=1,2,3,4 (Y=Z=0) -> 1 cycle after the 4th strobe:
//     READY=1, INTR=1, read X = 32'h00000002.
//  2. AVG_LOG2=2, X=-1,-1,-1,-2 -> X snapshot = -2 (floor).
//     Read X = 32'hFFFFFFFE; Y/Z reads sign-extend.
//  3. Two complete blocks with no Z read -> STATUS = 32'h00000103.
//     Read STATUS again -> 32'h00000001. Read Z -> READY=0, INTR=0.
//  4. Force 300 overruns -> OVF_CNT=255 (saturated).
//     A STATUS read clears OVR and OVF_CNT.
//  5. Z read in the same cycle as a commit -> RDATA=old Z, READY=1 afterwards,
//     OVR=0.
//  6. Assert RST after 2 of 4 samples, then supply 4 samples -> average uses
//     only post-reset samples. ENABLE=0 mid-block behaves the same, except
//     READY and the snapshot are retained.

Source files
------------

// File: rtl/gyro_sample_port.sv
// Gyro tilt decimator: block-averages 2**AVG_LOG2 X/Y/Z samples into a coherent snapshot
// and exposes it through a 4-word read-only MMIO register file.
module gyro_sample_port #(
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        SAMPLE_VALID,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [15:0] Z,
    input  logic        RD,
    input  logic [1:0]  ADDR,
    output logic [31:0] RDATA,
    output logic        INTR
);

    localparam int unsigned AW = 16 + AVG_LOG2;
    localparam int unsigned CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LastCnt = CW'((1 << AVG_LOG2) - 1);

    localparam logic [0:0] StAcc    = 1'b0;
    localparam logic [0:0] StCommit = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q [3];
    logic signed [AW-1:0] acc_d [3];
    logic signed [15:0]   snap_q [3];
    logic signed [15:0]   snap_d [3];
    logic                 ready_q, ready_d;
    logic                 ovr_q, ovr_d;
    logic [7:0]           ovf_cnt_q, ovf_cnt_d;
    logic [31:0]          rdata_q, rdata_d;

    logic signed [15:0]   sample [3];
    logic signed [AW-1:0] acc_base [3];
    logic signed [AW-1:0] sample_ext [3];
    logic signed [AW-1:0] sum [3];
    logic                 commit, rd_status, rd_z, overrun;

    always_comb begin
        sample[0] = X;
        sample[1] = Y;
        sample[2] = Z;
        commit    = ENABLE && SAMPLE_VALID && (cnt_q == LastCnt);
        state_d   = commit ? StCommit : StAcc;

        cnt_d = cnt_q;
        if (!ENABLE || commit) begin
            cnt_d = '0;
        end else if (SAMPLE_VALID) begin
            cnt_d = cnt_q + 1'b1;
        end

        for (int i = 0; i < 3; i++) begin
            // The stale sum is left in place on commit; the COMMIT state restarts from zero.
            acc_base[i]   = (state_q == StCommit) ? '0 : acc_q[i];
            sample_ext[i] = AW'(sample[i]);
            sum[i]        = acc_base[i] + sample_ext[i];
            snap_d[i]     = snap_q[i];
            if (!ENABLE) begin
                acc_d[i] = '0;
            end else if (commit) begin
                acc_d[i]  = acc_q[i];
                snap_d[i] = 16'(sum[i] >>> AVG_LOG2);
            end else if (SAMPLE_VALID) begin
                acc_d[i] = sum[i];
            end else begin
                acc_d[i] = acc_base[i];
            end
        end
    end

    always_comb begin
        rd_status = RD && (ADDR == 2'd0);
        rd_z      = RD && (ADDR == 2'd3);
        // A Z read in the commit cycle consumes the old data, so it is not an overrun.
        overrun   = commit && ready_q && !rd_z;

        ready_d = ready_q;
        if (commit) begin
            ready_d = 1'b1;
        end else if (rd_z) begin
            ready_d = 1'b0;
        end

        ovr_d = ovr_q;
        if (overrun) begin
            ovr_d = 1'b1;
        end else if (rd_status) begin
            ovr_d = 1'b0;
        end

        ovf_cnt_d = ovf_cnt_q;
        if (overrun) begin
            if (rd_status) begin
                ovf_cnt_d = 8'd1;
            end else if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
        end else if (rd_status) begin
            ovf_cnt_d = 8'd0;
        end

        rdata_d = rdata_q;
        if (RD) begin
            unique case (ADDR)
                2'd0: rdata_d = {16'b0, ovf_cnt_q, 6'b0, ovr_q, ready_q};
                2'd1: rdata_d = 32'(snap_q[0]);
                2'd2: rdata_d = 32'(snap_q[1]);
                2'd3: rdata_d = 32'(snap_q[2]);
                default: rdata_d = rdata_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StAcc;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
            rdata_q   <= 32'd0;
            for (int i = 0; i < 3; i++) begin
                acc_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            ovf_cnt_q <= ovf_cnt_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < 3; i++) begin
                acc_q[i]  <= acc_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign RDATA = rdata_q;
    assign INTR  = ready_q;

endmodule
